// File: rtl/packet_gen_mc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | packet_gen_mc : AXI4-Stream packet generator (counter/ramp/LFSR payload) |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module packet_gen_mc #(
    parameter int DW = 512
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [15:0]       length_min,
    input  logic [15:0]       length_max,
    input  logic [31:0]       packet_count,
    input  logic [15:0]       idle_cycles,
    input  logic [31:0]       initial_value,
    input  logic [1:0]        pattern_mode,
    input  logic              sweep,
    input  logic              start,
    input  logic              stop,
    output logic              busy,
    output logic              cfg_error,
    output logic [31:0]       packets_sent,
    output logic [DW-1:0]     axis_out_tdata,
    output logic [DW/8-1:0]   axis_out_tkeep,
    output logic              axis_out_tlast,
    output logic              axis_out_tvalid,
    input  logic              axis_out_tready
);

    localparam int DB = DW / 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t          r_state,        w_state;
    logic [15:0]     r_len_min,      w_len_min;
    logic [15:0]     r_len_max,      w_len_max;
    logic [31:0]     r_pkt_count,    w_pkt_count;
    logic [15:0]     r_idle_cycles,  w_idle_cycles;
    logic [1:0]      r_mode,         w_mode;
    logic            r_sweep,        w_sweep;
    logic [31:0]     r_pat,          w_pat;
    logic [15:0]     r_cur_len,      w_cur_len;
    logic [15:0]     r_beat,         w_beat;
    logic [15:0]     r_delay,        w_delay;
    logic            r_stop_pend,    w_stop_pend;
    logic            r_cfg_error,    w_cfg_error;
    logic [31:0]     r_packets_sent, w_packets_sent;
    logic [DW-1:0]   r_tdata,        w_tdata;
    logic [DB-1:0]   r_tkeep,        w_tkeep;
    logic            r_tlast,        w_tlast;
    logic            r_tvalid,       w_tvalid;
    logic            w_hs;
    logic            w_load;

    function automatic logic [DW-1:0] f_pat_data(input logic [1:0] mode, input logic [31:0] p);
        logic [DW-1:0] d;
        d = '0;
        case (mode)
            2'd0:    for (int i = 0; i < DW/16; i++) d[16*i +: 16] = p[15:0];
            2'd1:    for (int i = 0; i < DB; i++)    d[8*i +: 8]   = p[7:0] + 8'(i);
            default: for (int i = 0; i < DW/32; i++) d[32*i +: 32] = p;
        endcase
        return d;
    endfunction

    function automatic logic [31:0] f_pat_next(input logic [1:0] mode, input logic [31:0] p);
        case (mode)
            2'd0:    return {16'h0, p[15:0] + 16'd1};
            2'd1:    return {24'h0, p[7:0] + 8'(DB)};
            default: return {p[30:0], p[31] ^ p[21] ^ p[1] ^ p[0]};
        endcase
    endfunction

    function automatic logic [15:0] f_beats(input logic [15:0] len);
        return 16'((17'(len) + 17'(DB - 1)) / 17'(DB));
    endfunction

    // Only a short final beat gets a partial, low-aligned byte mask.
    function automatic logic [DB-1:0] f_keep(input logic last, input logic [15:0] len);
        logic [DB-1:0] k;
        logic [15:0]   rem;
        k   = '1;
        rem = len % 16'(DB);
        if (last && rem != 16'd0)
            for (int i = 0; i < DB; i++) k[i] = (16'(i) < rem);
        return k;
    endfunction

    assign w_hs = r_tvalid & axis_out_tready;

    always_comb begin
        w_state        = r_state;
        w_len_min      = r_len_min;
        w_len_max      = r_len_max;
        w_pkt_count    = r_pkt_count;
        w_idle_cycles  = r_idle_cycles;
        w_mode         = r_mode;
        w_sweep        = r_sweep;
        w_pat          = r_pat;
        w_cur_len      = r_cur_len;
        w_beat         = r_beat;
        w_delay        = r_delay;
        w_stop_pend    = r_stop_pend;
        w_cfg_error    = r_cfg_error;
        w_packets_sent = r_packets_sent;
        w_tdata        = r_tdata;
        w_tkeep        = r_tkeep;
        w_tlast        = r_tlast;
        w_tvalid       = r_tvalid;
        w_load         = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start && !stop) begin
                    w_len_min     = length_min;
                    w_len_max     = length_max;
                    w_pkt_count   = packet_count;
                    w_idle_cycles = idle_cycles;
                    w_mode        = pattern_mode;
                    w_sweep       = sweep;
                    if (length_min == 16'd0 || length_min > length_max || pattern_mode == 2'd3) begin
                        w_cfg_error = 1'b1;
                    end else begin
                        w_cfg_error    = 1'b0;
                        w_packets_sent = 32'd0;
                        w_pat          = (pattern_mode == 2'd2 && initial_value == 32'd0) ? 32'd1 : initial_value;
                        w_cur_len      = length_min;
                        w_beat         = 16'd1;
                        w_state        = S_SEND;
                        w_load         = 1'b1;
                    end
                end
            end
            S_SEND: begin
                if (w_hs) begin
                    w_pat = f_pat_next(r_mode, r_pat);
                    if (r_tlast) begin
                        w_beat         = 16'd1;
                        w_packets_sent = (r_packets_sent == 32'hFFFF_FFFF) ? r_packets_sent : r_packets_sent + 32'd1;
                        if (r_sweep)
                            w_cur_len = (r_cur_len == r_len_max) ? r_len_min : r_cur_len + 16'd1;
                        if (stop || r_stop_pend ||
                            (r_pkt_count != 32'd0 && r_packets_sent + 32'd1 == r_pkt_count)) begin
                            w_state     = S_IDLE;
                            w_tvalid    = 1'b0;
                            w_stop_pend = 1'b0;
                        end else if (r_idle_cycles != 16'd0) begin
                            w_state  = S_GAP;
                            w_delay  = r_idle_cycles - 16'd1;
                            w_tvalid = 1'b0;
                        end else begin
                            w_load = 1'b1;
                        end
                    end else begin
                        w_beat = r_beat + 16'd1;
                        w_load = 1'b1;
                        if (stop) w_stop_pend = 1'b1;
                    end
                end else if (stop) begin
                    w_stop_pend = 1'b1;
                end
            end
            S_GAP: begin
                if (stop) begin
                    w_state     = S_IDLE;
                    w_stop_pend = 1'b0;
                end else if (r_delay == 16'd0) begin
                    w_state = S_SEND;
                    w_load  = 1'b1;
                end else begin
                    w_delay = r_delay - 16'd1;
                end
            end
            default: w_state = S_IDLE;
        endcase

        // Present the beat described by the post-update pattern/beat/length.
        if (w_load) begin
            w_tvalid = 1'b1;
            w_tlast  = (w_beat == f_beats(w_cur_len));
            w_tdata  = f_pat_data(w_mode, w_pat);
            w_tkeep  = f_keep(w_tlast, w_cur_len);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state        <= S_IDLE;
            r_len_min      <= '0;
            r_len_max      <= '0;
            r_pkt_count    <= '0;
            r_idle_cycles  <= '0;
            r_mode         <= '0;
            r_sweep        <= 1'b0;
            r_pat          <= '0;
            r_cur_len      <= '0;
            r_beat         <= 16'd1;
            r_delay        <= '0;
            r_stop_pend    <= 1'b0;
            r_cfg_error    <= 1'b0;
            r_packets_sent <= '0;
            r_tdata        <= '0;
            r_tkeep        <= '1;
            r_tlast        <= 1'b0;
            r_tvalid       <= 1'b0;
        end else begin
            r_state        <= w_state;
            r_len_min      <= w_len_min;
            r_len_max      <= w_len_max;
            r_pkt_count    <= w_pkt_count;
            r_idle_cycles  <= w_idle_cycles;
            r_mode         <= w_mode;
            r_sweep        <= w_sweep;
            r_pat          <= w_pat;
            r_cur_len      <= w_cur_len;
            r_beat         <= w_beat;
            r_delay        <= w_delay;
            r_stop_pend    <= w_stop_pend;
            r_cfg_error    <= w_cfg_error;
            r_packets_sent <= w_packets_sent;
            r_tdata        <= w_tdata;
            r_tkeep        <= w_tkeep;
            r_tlast        <= w_tlast;
            r_tvalid       <= w_tvalid;
        end
    end

    assign busy            = (r_state != S_IDLE);
    assign cfg_error       = r_cfg_error;
    assign packets_sent    = r_packets_sent;
    assign axis_out_tdata  = r_tdata;
    assign axis_out_tkeep  = r_tkeep;
    assign axis_out_tlast  = r_tlast;
    assign axis_out_tvalid = r_tvalid;

endmodule
`default_nettype wire

// File: tb/tb_packet_gen_mc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_packet_gen_mc : directed self-checking bench for packet_gen_mc        |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_packet_gen_mc;

    localparam int DW = 512;
    localparam int DB = DW / 8;
    localparam logic [63:0] c_ones = 64'hFFFF_FFFF_FFFF_FFFF;

    logic          clk;
    logic          resetn;
    logic [15:0]   length_min, length_max, idle_cycles;
    logic [31:0]   packet_count, initial_value;
    logic [1:0]    pattern_mode;
    logic          sweep, start, stop;
    logic          busy, cfg_error;
    logic [31:0]   packets_sent;
    logic [DW-1:0] tdata;
    logic [DB-1:0] tkeep;
    logic          tlast, tvalid, tready;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] d;
    logic [DB-1:0] k;
    logic          l;
    int            g;

    packet_gen_mc #(.DW(DW)) u_dut (
        .clk             (clk),
        .resetn          (resetn),
        .length_min      (length_min),
        .length_max      (length_max),
        .packet_count    (packet_count),
        .idle_cycles     (idle_cycles),
        .initial_value   (initial_value),
        .pattern_mode    (pattern_mode),
        .sweep           (sweep),
        .start           (start),
        .stop            (stop),
        .busy            (busy),
        .cfg_error       (cfg_error),
        .packets_sent    (packets_sent),
        .axis_out_tdata  (tdata),
        .axis_out_tkeep  (tkeep),
        .axis_out_tlast  (tlast),
        .axis_out_tvalid (tvalid),
        .axis_out_tready (tready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] rep16(input logic [15:0] v);
        logic [DW-1:0] r;
        for (int i = 0; i < DW/16; i++) r[16*i +: 16] = v;
        return r;
    endfunction

    function automatic logic [DW-1:0] rep32(input logic [31:0] v);
        logic [DW-1:0] r;
        for (int i = 0; i < DW/32; i++) r[32*i +: 32] = v;
        return r;
    endfunction

    function automatic logic [DW-1:0] ramp(input logic [7:0] b);
        logic [DW-1:0] r;
        for (int i = 0; i < DB; i++) r[8*i +: 8] = b + 8'(i);
        return r;
    endfunction

    task automatic cfg(input logic [15:0] mn, input logic [15:0] mx, input logic [31:0] cnt,
                       input logic [15:0] idl, input logic [31:0] init, input logic [1:0] md,
                       input logic sw);
        length_min = mn; length_max = mx; packet_count = cnt; idle_cycles = idl;
        initial_value = init; pattern_mode = md; sweep = sw;
    endtask

    task automatic pulse_start;
        start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    // Waits for the next accepted beat, counting tvalid-low cycles and
    // checking that a stalled beat holds its payload.
    task automatic get_beat(input bit rnd, output logic [DW-1:0] od, output logic [DB-1:0] ok,
                            output logic ol, output int gaps);
        logic          got, stalled;
        logic [DW-1:0] sd;
        logic [DB-1:0] sk;
        logic          sl;
        got = 1'b0; stalled = 1'b0; gaps = 0;
        od = '0; ok = '0; ol = 1'b0; sd = '0; sk = '0; sl = 1'b0;
        for (int c = 0; c < 500 && !got; c++) begin
            if (stalled) begin
                check("stall_valid", DW'(tvalid), DW'(1));
                check("stall_data", tdata, sd);
                check("stall_keep", DW'(tkeep), DW'(sk));
                check("stall_last", DW'(tlast), DW'(sl));
            end
            tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (tvalid && tready) begin
                od = tdata; ok = tkeep; ol = tlast; got = 1'b1;
            end else begin
                stalled = tvalid;
                sd = tdata; sk = tkeep; sl = tlast;
                if (!tvalid) gaps++;
            end
            tick;
        end
        check("beat_seen", DW'(got), DW'(1));
    endtask

    logic [63:0] k2 [5] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                            64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001,
                            64'h7FFF_FFFF_FFFF_FFFF};
    logic        l2 [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [7:0]  b2 [5] = '{8'h00, 8'h40, 8'h80, 8'hC0, 8'h00};

    initial begin
        logic [31:0] s;
        resetn = 1'b0; start = 1'b0; stop = 1'b0; tready = 1'b1;
        cfg(16'd0, 16'd0, 32'd0, 16'd0, 32'd0, 2'd0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", DW'(tvalid), DW'(0));
        check("rst_busy", DW'(busy), DW'(0));
        check("rst_cfgerr", DW'(cfg_error), DW'(0));
        check("rst_sent", DW'(packets_sent), DW'(0));
        check("rst_keep", DW'(tkeep), DW'(c_ones));
        check("rst_data", tdata, '0);
        check("rst_last", DW'(tlast), DW'(0));
        resetn = 1'b1;
        tick;

        // Fixed length 100, word counter, 2-cycle gaps
        cfg(16'd100, 16'd100, 32'd3, 16'd2, 32'h1234, 2'd0, 1'b0);
        pulse_start;
        check("t1_first_valid", DW'(tvalid), DW'(1));
        check("t1_busy", DW'(busy), DW'(1));
        for (int i = 0; i < 6; i++) begin
            get_beat(1'b0, d, k, l, g);
            check($sformatf("t1_data%0d", i), d, rep16(16'h1234 + 16'(i)));
            check($sformatf("t1_keep%0d", i), DW'(k), DW'((i % 2) ? 64'h0000_000F_FFFF_FFFF : c_ones));
            check($sformatf("t1_last%0d", i), DW'(l), DW'(i % 2));
            check($sformatf("t1_gap%0d", i), DW'(g), DW'((i == 2 || i == 4) ? 2 : 0));
        end
        check("t1_busy_end", DW'(busy), DW'(0));
        check("t1_sent", DW'(packets_sent), DW'(3));
        tick;

        // Length sweep 63..65, byte ramp
        cfg(16'd63, 16'd65, 32'd4, 16'd0, 32'd0, 2'd1, 1'b1);
        pulse_start;
        for (int i = 0; i < 5; i++) begin
            get_beat(1'b0, d, k, l, g);
            check($sformatf("t2_data%0d", i), d, ramp(b2[i]));
            check($sformatf("t2_keep%0d", i), DW'(k), DW'(k2[i]));
            check($sformatf("t2_last%0d", i), DW'(l), DW'(l2[i]));
        end
        check("t2_busy_end", DW'(busy), DW'(0));
        check("t2_sent", DW'(packets_sent), DW'(4));
        tick;

        // LFSR with zero seed under random backpressure
        cfg(16'd100, 16'd100, 32'd3, 16'd1, 32'd0, 2'd2, 1'b0);
        pulse_start;
        s = 32'h1;
        for (int i = 0; i < 6; i++) begin
            get_beat(1'b1, d, k, l, g);
            if (i == 0) check("t3_word0", DW'(d[31:0]), DW'(32'h1));
            if (i == 1) check("t3_word1", DW'(d[31:0]), DW'(32'h3));
            check($sformatf("t3_data%0d", i), d, rep32(s));
            check($sformatf("t3_last%0d", i), DW'(l), DW'(i % 2));
            check($sformatf("t3_gap%0d", i), DW'(g), DW'((i == 2 || i == 4) ? 1 : 0));
            s = {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
        end
        check("t3_sent", DW'(packets_sent), DW'(3));
        tready = 1'b1;
        tick;

        // Continuous stream, stop on beat 2 of packet 5
        cfg(16'd200, 16'd200, 32'd0, 16'd0, 32'd0, 2'd0, 1'b0);
        pulse_start;
        for (int i = 0; i < 17; i++) begin
            get_beat(1'b0, d, k, l, g);
            check($sformatf("t4_data%0d", i), d, rep16(16'(i)));
            check($sformatf("t4_last%0d", i), DW'(l), DW'(i % 4 == 3));
        end
        check("t4_stop_valid", DW'(tvalid), DW'(1));
        check("t4_stop_data", tdata, rep16(16'd17));
        stop = 1'b1; tready = 1'b1;
        tick;
        stop = 1'b0;
        for (int i = 18; i < 20; i++) begin
            get_beat(1'b0, d, k, l, g);
            check($sformatf("t4_data%0d", i), d, rep16(16'(i)));
            check($sformatf("t4_last%0d", i), DW'(l), DW'(i == 19));
            if (i == 19) check("t4_keep_last", DW'(k), DW'(64'hFF));
        end
        check("t4_busy_end", DW'(busy), DW'(0));
        check("t4_sent", DW'(packets_sent), DW'(5));
        tick;
        check("t4_quiet", DW'(tvalid), DW'(0));

        // Configuration rejection
        for (int c = 0; c < 3; c++) begin
            case (c)
                0:       cfg(16'd0,  16'd10, 32'd1, 16'd0, 32'd0, 2'd0, 1'b0);
                1:       cfg(16'd10, 16'd5,  32'd1, 16'd0, 32'd0, 2'd0, 1'b0);
                default: cfg(16'd4,  16'd4,  32'd1, 16'd0, 32'd0, 2'd3, 1'b0);
            endcase
            pulse_start;
            check($sformatf("t5_err%0d", c), DW'(cfg_error), DW'(1));
            for (int j = 0; j < 3; j++) begin
                check($sformatf("t5_busy%0d", c), DW'(busy), DW'(0));
                check($sformatf("t5_valid%0d", c), DW'(tvalid), DW'(0));
                tick;
            end
        end
        cfg(16'd4, 16'd4, 32'd1, 16'd0, 32'hABCD, 2'd0, 1'b0);
        start = 1'b1; stop = 1'b1;
        tick;
        start = 1'b0; stop = 1'b0;
        check("t5_startstop_busy", DW'(busy), DW'(0));
        check("t5_startstop_err", DW'(cfg_error), DW'(1));
        pulse_start;
        check("t5_err_clear", DW'(cfg_error), DW'(0));
        check("t5_busy_ok", DW'(busy), DW'(1));
        get_beat(1'b0, d, k, l, g);
        check("t5_data", d, rep16(16'hABCD));
        check("t5_keep", DW'(k), DW'(64'hF));
        check("t5_last", DW'(l), DW'(1));
        check("t5_sent", DW'(packets_sent), DW'(1));

        // Asynchronous reset in the middle of a packet
        cfg(16'd100, 16'd100, 32'd0, 16'd0, 32'h55, 2'd0, 1'b0);
        pulse_start;
        for (int i = 0; i < 3; i++) get_beat(1'b0, d, k, l, g);
        check("t6_pre_sent", DW'(packets_sent), DW'(1));
        check("t6_pre_valid", DW'(tvalid), DW'(1));
        resetn = 1'b0;
        #1;
        check("t6_valid", DW'(tvalid), DW'(0));
        check("t6_busy", DW'(busy), DW'(0));
        check("t6_sent", DW'(packets_sent), DW'(0));
        check("t6_keep", DW'(tkeep), DW'(c_ones));
        check("t6_data", tdata, '0);
        check("t6_last", DW'(tlast), DW'(0));
        tick;
        resetn = 1'b1;
        tick;
        pulse_start;
        get_beat(1'b0, d, k, l, g);
        check("t6_restart_data", d, rep16(16'h0055));
        check("t6_restart_last", DW'(l), DW'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
